// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary decoder using iterative reverse double-dabble.
// One bit of the binary result is produced per clock while in SHIFT.
module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BCD_W-1:0]   sr_bcd;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [BIN_W-1:0]   sr_bin;
  logic [BIN_W-1:0]   bin_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               in_valid;
  logic               last_iter;

  // A code is convertible only if every nibble is a decimal digit.
  always_comb begin
    in_valid = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_in[4*k +: 4] > 4'd9) begin
        in_valid = 1'b0;
      end
    end
  end

  // Shift the BCD/binary pair right, then correct digits that underflowed past 4.
  always_comb begin
    {bcd_nxt, bin_nxt} = {1'b0, sr_bcd, sr_bin[BIN_W-1:1]};
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_nxt[4*k +: 4] >= 4'd8) begin
        bcd_nxt[4*k +: 4] = bcd_nxt[4*k +: 4] - 4'd3;
      end
    end
  end

  assign last_iter = (cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = in_valid ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_bcd  <= '0;
      sr_bin  <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr_bcd <= bcd_in;
            sr_bin <= '0;
            cnt    <= '0;
            err    <= ~in_valid;
            if (!in_valid) begin
              bin_out <= '0;
            end
          end
        end
        SHIFT: begin
          sr_bcd <= bcd_nxt;
          sr_bin <= bin_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            bin_out <= bin_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary decoder, the inverse of the team's BCD adder datapath. It takes a packed multi-digit BCD word (the adder's 8-bit two-digit result by default) and returns its unsigned binary value. It uses iterative reverse double-dabble, one bit per clock. It sits downstream of the BCD arithmetic blocks so that their results can be compared, scaled or stored in binary.

## Interface
- DIGITS, 2, number of BCD digits in `bcd_in`.
- BIN_W, 7, width of `bin_out`. Must satisfy 2^BIN_W >= 10^DIGITS. The default covers 0..99.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request pulse. Sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in bits [3:0]. Sampled on the edge that accepts `start`.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; `bin_out` and `err` are valid in that cycle.
- bin_out  output  BIN_W  converted value. Held until the next `done`.
- err  output  1  the sampled `bcd_in` contained a digit > 9. Held until the next accepted `start`.

## Operation
- Internal registers:
  - `sr_bcd` (4*DIGITS bits).
  - `sr_bin` (BIN_W bits).
  - iteration counter `cnt`, wide enough for 0..BIN_W.
  - state.
- IDLE:
  - On `start`=1, latch `bcd_in` into `sr_bcd`, clear `sr_bin` and `cnt`, and clear `err`.
  - If every nibble of `bcd_in` is <= 9, go to SHIFT.
  - Otherwise set `err`=1, load `bin_out`=0 and go to DONE.
- SHIFT, one iteration per edge:
  - Shift the concatenation {sr_bcd, sr_bin} right by 1. The LSB of `sr_bcd` enters the MSB of `sr_bin`, and 0 enters the MSB of `sr_bcd`.
  - After the shift, subtract 3 from every nibble of `sr_bcd` that is >= 8. All nibbles are adjusted in parallel in the same cycle.
  - Increment `cnt`.
  - On the edge completing iteration BIN_W, load `bin_out` from the post-shift `sr_bin` and go to DONE.
- DONE:
  - `done`=1 for exactly this one cycle, then IDLE unconditionally.
  - `start` is ignored in DONE.
- `start` during SHIFT or DONE is ignored. There is no queueing and no effect on the conversion in flight.
- `bcd_in` is don't-care except on the accepting edge. Changes during SHIFT do not affect the result.
- Arithmetic:
  - Unsigned only.
  - For valid input, `bin_out` = sum of digit_k * 10^k.
  - After BIN_W iterations `sr_bcd` is all-zero. The bench may check this as an internal assertion.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, bin_out=0, err=0.
  - sr_bcd=0, sr_bin=0, cnt=0.
- Valid input:
  - `start` is accepted at edge E.
  - `busy` is high from E to E+BIN_W.
  - `done` is high in the cycle after edge E+BIN_W.
  - Latency is BIN_W cycles from the accepting edge to `done` (7 for the default).
- Invalid input: `done` and `err` are high in the cycle after the accepting edge E (latency 1). `busy` never rises.
- Back-to-back: the earliest next accept is the edge ending the DONE cycle plus one, i.e. the first IDLE cycle. Throughput is one conversion per BIN_W+2 cycles.
- Reset asserted mid-conversion:
  - All outputs return immediately, asynchronously, to their reset values.
  - The partial result is discarded and no `done` is produced.
  - After deassertion the block is in IDLE.
- `done` and `busy` are never high together.

## Test plan
- Reset, then `bcd_in`=8'h00 with `start` -> `done` 7 cycles after the accept, `bin_out`=0, `err`=0.
- `bcd_in`=8'h99 -> `bin_out`=99 (7'h63). Check also 8'h42 -> 42 and 8'h10 -> 10. `busy` is high for exactly 7 cycles in each case.
- Exhaustive: every n1+n2 result produced by the BCD adder for n1,n2 in 0..9 (8'h00..8'h18) -> `bin_out` equals the decimal sum. Also sweep all 100 valid two-digit codes.
- Invalid `bcd_in`=8'h3A, then 8'hF0 -> `done` and `err`=1 one cycle after the accept, `bin_out`=0, `busy` stays 0. A following valid 8'h25 clears `err` and yields 25.
- Pulse `start` with 8'h77 at cycles 2 and 5 after accepting 8'h31 -> a single `done` with `bin_out`=31. 8'h77 is never converted.
- Assert `rst` 3 cycles into converting 8'h88 -> outputs are 0 immediately and no `done` appears. After release, 8'h88 yields 88 with `err`=0.
